// File: rtl/sram_arbiter.sv
// sram_arbiter: two-core round-robin arbiter in front of a synchronous
// pipelined SRAM (ADSC-started accesses).
//
// Ports
//   clock, reset_n          : system clock, async active-low reset
//   cN_req/we/addr/wdata/be : core N command (held until cN_gnt)
//   cN_gnt                  : 1-cycle pulse when core N's command hits the SRAM
//   cN_rvalid/cN_rdata      : read return, 3 cycles after cN_gnt
//   SRAM_*                  : SRAM control/address pins (all registered)
//   sram_dq_o/oe, sram_dq_i : split data bus, tristate resolved above
//   busy                    : FSM not IDLE
//
// Write = WR + IDLE (2 cycles), read = RD_ADDR/RD_WAIT/RD_DATA + IDLE
// (4 cycles). The mandatory IDLE after each access is the read-to-write
// bus turnaround, so dq_oe can never overlap OE_N low.
module sram_arbiter #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  c0_req,
  input  logic                  c0_we,
  input  logic [ADDR_W-1:0]     c0_addr,
  input  logic [DATA_W-1:0]     c0_wdata,
  input  logic [DATA_W/8-1:0]   c0_be,
  output logic                  c0_gnt,
  output logic                  c0_rvalid,
  output logic [DATA_W-1:0]     c0_rdata,
  input  logic                  c1_req,
  input  logic                  c1_we,
  input  logic [ADDR_W-1:0]     c1_addr,
  input  logic [DATA_W-1:0]     c1_wdata,
  input  logic [DATA_W/8-1:0]   c1_be,
  output logic                  c1_gnt,
  output logic                  c1_rvalid,
  output logic [DATA_W-1:0]     c1_rdata,
  output logic [ADDR_W-1:0]     SRAM_A,
  output logic                  SRAM_ADSC_N,
  output logic                  SRAM_ADSP_N,
  output logic                  SRAM_ADV_N,
  output logic                  SRAM_GW_N,
  output logic                  SRAM_CE1_N,
  output logic                  SRAM_CE2,
  output logic                  SRAM_CE3_N,
  output logic                  SRAM_OE_N,
  output logic                  SRAM_WE_N,
  output logic [DATA_W/8-1:0]   SRAM_BE_N,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  busy
);

  localparam int BE_W = DATA_W / 8;

  typedef enum logic [2:0] {IDLE, WR, RD_ADDR, RD_WAIT, RD_DATA} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              adsc_n;
    logic              ce1_n;
    logic              ce2;
    logic              ce3_n;
    logic              oe_n;
    logic              we_n;
    logic [BE_W-1:0]   be_n;
    logic [DATA_W-1:0] dq;
    logic              dq_oe;
  } sram_cmd_t;

  // Pin state whenever no command is being issued (also the reset state).
  localparam sram_cmd_t CMD_IDLE = '{
    addr: '0, adsc_n: 1'b1, ce1_n: 1'b1, ce2: 1'b0, ce3_n: 1'b1,
    oe_n: 1'b1, we_n: 1'b1, be_n: '1, dq: '0, dq_oe: 1'b0
  };

  // Per-core request fields gathered into packed arrays, indexed by core.
  logic [1:0]                  req, we;
  logic [1:0][ADDR_W-1:0]      addr;
  logic [1:0][DATA_W-1:0]      wdata;
  logic [1:0][BE_W-1:0]        be;

  assign req   = {c1_req,   c0_req};
  assign we    = {c1_we,    c0_we};
  assign addr  = {c1_addr,  c0_addr};
  assign wdata = {c1_wdata, c0_wdata};
  assign be    = {c1_be,    c0_be};

  state_e                 state_q;
  sram_cmd_t              cmd_q;
  logic                   last_q;   // core granted most recently
  logic                   own_q;    // core owning the access in flight
  logic                   busy_q;
  logic [1:0]             gnt_q, rvalid_q;
  logic [1:0][DATA_W-1:0] rdata_q;

  // Core 1 wins if alone, or on a tie when core 0 was granted last.
  logic win;
  assign win = req[1] & (~req[0] | ~last_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cmd_q    <= CMD_IDLE;
      last_q   <= 1'b1;
      own_q    <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      gnt_q    <= '0;
      rvalid_q <= '0;
      cmd_q    <= CMD_IDLE;
      case (state_q)
        IDLE: begin
          if (|req) begin
            last_q       <= win;
            own_q        <= win;
            gnt_q[win]   <= 1'b1;
            busy_q       <= 1'b1;
            cmd_q.addr   <= addr[win];
            cmd_q.adsc_n <= 1'b0;
            cmd_q.ce1_n  <= 1'b0;
            cmd_q.ce2    <= 1'b1;
            cmd_q.ce3_n  <= 1'b0;
            if (we[win]) begin
              state_q     <= WR;
              cmd_q.we_n  <= 1'b0;
              cmd_q.be_n  <= ~be[win];
              cmd_q.dq    <= wdata[win];
              cmd_q.dq_oe <= 1'b1;
            end else begin
              state_q    <= RD_ADDR;
              cmd_q.be_n <= '0;
            end
          end
        end
        WR: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        RD_ADDR: begin
          state_q    <= RD_WAIT;
          cmd_q.oe_n <= 1'b0;
        end
        RD_WAIT: begin
          state_q    <= RD_DATA;
          cmd_q.oe_n <= 1'b0;
        end
        RD_DATA: begin
          // SRAM drives dq during this cycle; sample it at the closing edge.
          state_q         <= IDLE;
          busy_q          <= 1'b0;
          rvalid_q[own_q] <= 1'b1;
          rdata_q[own_q]  <= sram_dq_i;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign c0_gnt      = gnt_q[0];
  assign c1_gnt      = gnt_q[1];
  assign c0_rvalid   = rvalid_q[0];
  assign c1_rvalid   = rvalid_q[1];
  assign c0_rdata    = rdata_q[0];
  assign c1_rdata    = rdata_q[1];

  assign SRAM_A      = cmd_q.addr;
  assign SRAM_ADSC_N = cmd_q.adsc_n;
  assign SRAM_ADSP_N = 1'b1;
  assign SRAM_ADV_N  = 1'b1;
  assign SRAM_GW_N   = 1'b1;
  assign SRAM_CE1_N  = cmd_q.ce1_n;
  assign SRAM_CE2    = cmd_q.ce2;
  assign SRAM_CE3_N  = cmd_q.ce3_n;
  assign SRAM_OE_N   = cmd_q.oe_n;
  assign SRAM_WE_N   = cmd_q.we_n;
  assign SRAM_BE_N   = cmd_q.be_n;
  assign sram_dq_o   = cmd_q.dq;
  assign sram_dq_oe  = cmd_q.dq_oe;
  assign busy        = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small synchronous SRAM model.
module tb_sram_arbiter;
  localparam int AW = 19;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic          c0_req, c0_we, c1_req, c1_we;
  logic [AW-1:0] c0_addr, c1_addr;
  logic [DW-1:0] c0_wdata, c1_wdata;
  logic [3:0]    c0_be, c1_be;
  logic          c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
  logic [DW-1:0] c0_rdata, c1_rdata;
  logic [AW-1:0] SRAM_A;
  logic          SRAM_ADSC_N, SRAM_ADSP_N, SRAM_ADV_N, SRAM_GW_N;
  logic          SRAM_CE1_N, SRAM_CE2, SRAM_CE3_N, SRAM_OE_N, SRAM_WE_N;
  logic [3:0]    SRAM_BE_N;
  logic [DW-1:0] sram_dq_o, sram_dq_i;
  logic          sram_dq_oe, busy;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n),
    .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_be(c0_be),
    .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
    .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
    .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
    .SRAM_A(SRAM_A), .SRAM_ADSC_N(SRAM_ADSC_N), .SRAM_ADSP_N(SRAM_ADSP_N),
    .SRAM_ADV_N(SRAM_ADV_N), .SRAM_GW_N(SRAM_GW_N), .SRAM_CE1_N(SRAM_CE1_N),
    .SRAM_CE2(SRAM_CE2), .SRAM_CE3_N(SRAM_CE3_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_BE_N(SRAM_BE_N),
    .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .busy(busy)
  );

  // {ADSC_N, ADSP_N, ADV_N, GW_N, CE1_N, CE2, CE3_N, OE_N, WE_N}
  logic [8:0] ctl;
  assign ctl = {SRAM_ADSC_N, SRAM_ADSP_N, SRAM_ADV_N, SRAM_GW_N,
                SRAM_CE1_N, SRAM_CE2, SRAM_CE3_N, SRAM_OE_N, SRAM_WE_N};
  localparam logic [8:0] CTL_RST = 9'b111110111;
  localparam logic [8:0] CTL_WR  = 9'b011101010;
  localparam logic [8:0] CTL_RDA = 9'b011101011;

  int checks = 0, fails = 0, contention = 0, dualgnt = 0;

  // SRAM model: latch address on ADSC with chip selected, byte-write on WE_N,
  // drive the latched word while OE_N is low.
  logic [31:0] mem [0:255] = '{default: '0};
  logic [7:0]  lat = '0;
  assign sram_dq_i = !SRAM_OE_N ? mem[lat] : '0;
  always @(posedge clock) begin
    if (!SRAM_ADSC_N && !SRAM_CE1_N && SRAM_CE2 && !SRAM_CE3_N) begin
      lat = SRAM_A[7:0];
      if (!SRAM_WE_N)
        for (int b = 0; b < 4; b++)
          if (!SRAM_BE_N[b]) mem[SRAM_A[7:0]][b*8 +: 8] = sram_dq_o[b*8 +: 8];
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (sram_dq_oe && !SRAM_OE_N) contention++;
      if (c0_gnt && c1_gnt) dualgnt++;
    end
  end

  task automatic drive(input bit c, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [3:0] be);
    if (!c) begin c0_req = r; c0_we = w; c0_addr = a; c0_wdata = d; c0_be = be; end
    else    begin c1_req = r; c1_we = w; c1_addr = a; c1_wdata = d; c1_be = be; end
  endtask

  task automatic test_reset;
    checks++; if ({c1_gnt, c0_gnt, c1_rvalid, c0_rvalid} !== 4'b0) begin fails++; $display("FAIL rst_pulses got=%b exp=0000", {c1_gnt, c0_gnt, c1_rvalid, c0_rvalid}); end
    checks++; if ({c1_rdata, c0_rdata} !== 64'h0) begin fails++; $display("FAIL rst_rdata got=%h exp=0", {c1_rdata, c0_rdata}); end
    checks++; if (ctl !== CTL_RST) begin fails++; $display("FAIL rst_ctl got=%b exp=%b", ctl, CTL_RST); end
    checks++; if (SRAM_A !== 19'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", SRAM_A); end
    checks++; if (SRAM_BE_N !== 4'hF) begin fails++; $display("FAIL rst_be_n got=%h exp=f", SRAM_BE_N); end
    checks++; if ({sram_dq_oe, sram_dq_o, busy} !== 34'h0) begin fails++; $display("FAIL rst_dq_busy got=%h exp=0", {sram_dq_oe, sram_dq_o, busy}); end
  endtask

  task automatic test_single_write;
    drive(0, 1, 1, 19'h00010, 32'hDEADBEEF, 4'hF);
    @(negedge clock);
    checks++; if ({c1_gnt, c0_gnt} !== 2'b01) begin fails++; $display("FAIL wr_gnt got=%b exp=01", {c1_gnt, c0_gnt}); end
    checks++; if (ctl !== CTL_WR) begin fails++; $display("FAIL wr_ctl got=%b exp=%b", ctl, CTL_WR); end
    checks++; if (SRAM_A !== 19'h00010) begin fails++; $display("FAIL wr_addr got=%h exp=10", SRAM_A); end
    checks++; if ({sram_dq_oe, sram_dq_o, SRAM_BE_N} !== {1'b1, 32'hDEADBEEF, 4'h0}) begin fails++; $display("FAIL wr_data got=%h exp=1deadbeef0", {sram_dq_oe, sram_dq_o, SRAM_BE_N}); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy got=%b exp=1", busy); end
    c0_req = 1'b0;
    @(negedge clock);
    checks++; if ({c1_gnt, c0_gnt, busy, sram_dq_oe} !== 4'b0) begin fails++; $display("FAIL wr_idle got=%b exp=0000", {c1_gnt, c0_gnt, busy, sram_dq_oe}); end
    checks++; if ({SRAM_ADSC_N, SRAM_WE_N, SRAM_BE_N} !== 6'h3F) begin fails++; $display("FAIL wr_idle_pins got=%h exp=3f", {SRAM_ADSC_N, SRAM_WE_N, SRAM_BE_N}); end
  endtask

  task automatic test_read_back;
    drive(0, 1, 0, 19'h00010, 32'h0, 4'h0);
    @(negedge clock);
    checks++; if ({c1_gnt, c0_gnt} !== 2'b01) begin fails++; $display("FAIL rd_gnt got=%b exp=01", {c1_gnt, c0_gnt}); end
    checks++; if ({ctl, SRAM_BE_N, sram_dq_oe} !== {CTL_RDA, 4'h0, 1'b0}) begin fails++; $display("FAIL rd_addr_pins got=%h exp=%h", {ctl, SRAM_BE_N, sram_dq_oe}, {CTL_RDA, 4'h0, 1'b0}); end
    c0_req = 1'b0;
    @(negedge clock);
    checks++; if ({SRAM_ADSC_N, SRAM_OE_N, c0_gnt, busy, c0_rvalid} !== 5'b10010) begin fails++; $display("FAIL rd_wait got=%b exp=10010", {SRAM_ADSC_N, SRAM_OE_N, c0_gnt, busy, c0_rvalid}); end
    @(negedge clock);
    checks++; if ({SRAM_OE_N, c0_rvalid, sram_dq_oe} !== 3'b000) begin fails++; $display("FAIL rd_data got=%b exp=000", {SRAM_OE_N, c0_rvalid, sram_dq_oe}); end
    @(negedge clock);
    checks++; if ({c1_rvalid, c0_rvalid, busy, SRAM_OE_N} !== 4'b0101) begin fails++; $display("FAIL rd_rvalid got=%b exp=0101", {c1_rvalid, c0_rvalid, busy, SRAM_OE_N}); end
    checks++; if (c0_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_rdata got=%h exp=deadbeef", c0_rdata); end
    @(negedge clock);
    checks++; if ({c0_rvalid, c0_rdata} !== {1'b0, 32'hDEADBEEF}) begin fails++; $display("FAIL rd_hold got=%h exp=0deadbeef", {c0_rvalid, c0_rdata}); end
  endtask

  task automatic test_tie;
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 1, 1, 19'h00020, 32'h11111111, 4'hF);
    drive(1, 1, 1, 19'h00021, 32'h22222222, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if ({c1_gnt, c0_gnt} !== (i[0] ? 2'b10 : 2'b01)) begin fails++; $display("FAIL tie_gnt%0d got=%b exp=%b", i, {c1_gnt, c0_gnt}, (i[0] ? 2'b10 : 2'b01)); end
      checks++; if (SRAM_A !== (i[0] ? 19'h00021 : 19'h00020)) begin fails++; $display("FAIL tie_addr%0d got=%h", i, SRAM_A); end
      @(negedge clock);
      checks++; if ({c1_gnt, c0_gnt} !== 2'b00) begin fails++; $display("FAIL tie_idle%0d got=%b exp=00", i, {c1_gnt, c0_gnt}); end
      if (i == 3) begin c0_req = 1'b0; c1_req = 1'b0; end
    end
    checks++; if (dualgnt !== 0) begin fails++; $display("FAIL tie_dual_gnt got=%0d exp=0", dualgnt); end
  endtask

  task automatic test_byte_write;
    drive(1, 1, 1, 19'h00030, 32'hAABBCCDD, 4'h5);
    @(negedge clock);
    checks++; if ({c1_gnt, c0_gnt, SRAM_BE_N} !== {2'b10, 4'hA}) begin fails++; $display("FAIL bw_be_n got=%h exp=2a", {c1_gnt, c0_gnt, SRAM_BE_N}); end
    checks++; if (sram_dq_o !== 32'hAABBCCDD) begin fails++; $display("FAIL bw_dq got=%h exp=aabbccdd", sram_dq_o); end
    c1_req = 1'b0;
    @(negedge clock);
    drive(1, 1, 0, 19'h00030, 32'h0, 4'h0);
    @(negedge clock);
    checks++; if (c1_gnt !== 1'b1) begin fails++; $display("FAIL bw_rd_gnt got=%b exp=1", c1_gnt); end
    c1_req = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if ({c1_rvalid, c0_rvalid, c1_rdata} !== {2'b10, 32'h00BB00DD}) begin fails++; $display("FAIL bw_readback got=%h exp=200bb00dd", {c1_rvalid, c0_rvalid, c1_rdata}); end
  endtask

  task automatic test_reset_mid_read;
    drive(0, 1, 0, 19'h00010, 32'h0, 4'h0);
    @(negedge clock);
    c0_req = 1'b0;
    @(negedge clock);
    checks++; if ({SRAM_OE_N, busy} !== 2'b01) begin fails++; $display("FAIL mr_in_wait got=%b exp=01", {SRAM_OE_N, busy}); end
    reset_n = 1'b0;
    #1;
    checks++; if ({ctl, SRAM_BE_N, sram_dq_oe, busy} !== {CTL_RST, 4'hF, 2'b00}) begin fails++; $display("FAIL mr_async got=%h exp=%h", {ctl, SRAM_BE_N, sram_dq_oe, busy}, {CTL_RST, 4'hF, 2'b00}); end
    checks++; if ({SRAM_A, c0_rdata} !== 51'h0) begin fails++; $display("FAIL mr_async_data got=%h exp=0", {SRAM_A, c0_rdata}); end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++; if ({c1_gnt, c0_gnt, c1_rvalid, c0_rvalid} !== 4'b0) begin fails++; $display("FAIL mr_quiet%0d got=%b exp=0000", i, {c1_gnt, c0_gnt, c1_rvalid, c0_rvalid}); end
    end
    drive(1, 1, 0, 19'h00010, 32'h0, 4'h0);
    @(negedge clock);
    checks++; if ({c1_gnt, c0_gnt} !== 2'b10) begin fails++; $display("FAIL mr_resume_gnt got=%b exp=10", {c1_gnt, c0_gnt}); end
    c1_req = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if ({c1_rvalid, c1_rdata} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL mr_resume_data got=%h exp=1deadbeef", {c1_rvalid, c1_rdata}); end
  endtask

  task automatic test_back_to_back;
    drive(0, 1, 0, 19'h00010, 32'h0, 4'h0);
    @(negedge clock);
    checks++; if (c0_gnt !== 1'b1) begin fails++; $display("FAIL bb_rd_gnt got=%b exp=1", c0_gnt); end
    c0_req = 1'b0;
    drive(1, 1, 1, 19'h00040, 32'h12345678, 4'hF);
    @(negedge clock);
    checks++; if ({c1_gnt, sram_dq_oe} !== 2'b00) begin fails++; $display("FAIL bb_wait got=%b exp=00", {c1_gnt, sram_dq_oe}); end
    @(negedge clock);
    checks++; if ({c1_gnt, sram_dq_oe, SRAM_OE_N} !== 3'b000) begin fails++; $display("FAIL bb_data got=%b exp=000", {c1_gnt, sram_dq_oe, SRAM_OE_N}); end
    @(negedge clock);
    checks++; if ({c0_rvalid, c1_gnt, sram_dq_oe} !== 3'b100) begin fails++; $display("FAIL bb_turnaround got=%b exp=100", {c0_rvalid, c1_gnt, sram_dq_oe}); end
    @(negedge clock);
    checks++; if ({c1_gnt, sram_dq_oe, SRAM_OE_N, SRAM_A} !== {3'b111, 19'h00040}) begin fails++; $display("FAIL bb_write got=%h exp=%h", {c1_gnt, sram_dq_oe, SRAM_OE_N, SRAM_A}, {3'b111, 19'h00040}); end
    c1_req = 1'b0;
    @(negedge clock);
    checks++; if (contention !== 0) begin fails++; $display("FAIL bb_contention got=%0d exp=0", contention); end
  endtask

  initial begin
    c0_req = 0; c0_we = 0; c0_addr = '0; c0_wdata = '0; c0_be = '0;
    c1_req = 0; c1_we = 0; c1_addr = '0; c1_wdata = '0; c1_be = '0;
    repeat (2) @(negedge clock);
    test_reset;
    reset_n = 1'b1;
    test_single_write;
    test_read_back;
    test_tie;
    test_byte_write;
    test_reset_mid_read;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 19, SRAM word-address width.
REQ-002 SHALL have parameter DATA_W, 32, SRAM data width; byte enables are DATA_W/8 wide.
REQ-003 SHALL have port clock  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports cN_req (N=0,1)  input  1  core N access request; held high until cN_gnt seen.
REQ-006 SHALL have ports cN_we  input  1  1=write, 0=read; stable while cN_req high.
REQ-007 SHALL have ports cN_addr  input  ADDR_W  word address; stable while cN_req high.
REQ-008 SHALL have ports cN_wdata  input  DATA_W  write data; cN_be  input  DATA_W/8  byte enables, active-high.
REQ-009 SHALL have ports cN_gnt  output  1  one-cycle pulse in the cycle core N's command is issued to SRAM.
REQ-010 SHALL have ports cN_rvalid  output  1  one-cycle pulse, cN_rdata  output  DATA_W  valid when cN_rvalid high.
REQ-011 SHALL have ports SRAM_A  output  ADDR_W; SRAM_ADSC_N, SRAM_ADSP_N, SRAM_ADV_N, SRAM_GW_N, SRAM_CE1_N, SRAM_CE2, SRAM_CE3_N, SRAM_OE_N, SRAM_WE_N  output  1 each; SRAM_BE_N  output  DATA_W/8.
REQ-012 SHALL have ports sram_dq_o  output  DATA_W, sram_dq_oe  output  1, sram_dq_i  input  DATA_W (tristate resolved at top level).
REQ-013 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, WR, RD_ADDR, RD_WAIT, RD_DATA; all outputs registered.
REQ-015 IDLE: if any cN_req high, SHALL select winner, next state WR (cN_we=1) or RD_ADDR (cN_we=0); else stay IDLE.
REQ-016 Arbitration SHALL be round-robin: sole requester wins; both requesting -> core not in last_grant wins; last_grant updated on every grant.
REQ-017 WR (1 cycle): SRAM_A=addr, ADSC_N=0, CE1_N=0, CE2=1, CE3_N=0, WE_N=0, OE_N=1, BE_N=~be, sram_dq_o=wdata, sram_dq_oe=1, winner's gnt=1; next IDLE.
REQ-018 RD_ADDR: SRAM_A=addr, ADSC_N=0, chip enables active, WE_N=1, OE_N=1, BE_N=all 0, dq_oe=0, winner's gnt=1; next RD_WAIT.
REQ-019 RD_WAIT: ADSC_N=1, OE_N=0; next RD_DATA. RD_DATA: OE_N=0, capture sram_dq_i at cycle end; next IDLE.
REQ-020 Read data SHALL appear on owner's cN_rdata with cN_rvalid=1 in the cycle after RD_DATA (3 cycles after gnt); cN_rdata holds last value otherwise.
REQ-021 SRAM_ADSP_N, SRAM_ADV_N, SRAM_GW_N SHALL be constant 1; outside WR/RD_ADDR: ADSC_N=1, WE_N=1, BE_N all 1.
REQ-022 sram_dq_oe SHALL be high only in WR, never while OE_N=0 (bus contention forbidden).
REQ-023 Throughput: write 2 cycles/access, read 4 cycles/access including IDLE; IDLE cycle guarantees read-to-write bus turnaround.
REQ-024 Requests arriving in non-IDLE states SHALL wait; never more than one gnt high per cycle.
REQ-025 Unselected core's gnt/rvalid SHALL stay 0.

Reset
REQ-026 reset_n low SHALL immediately force IDLE, last_grant=1 (core 0 wins first tie), all gnt/rvalid=0, rdata=0, SRAM_A=0, CE1_N=1, CE2=0, CE3_N=1, OE_N=1, WE_N=1, ADSC_N=1, BE_N all 1, dq_oe=0, dq_o=0, busy=0.
REQ-027 Reset mid-access SHALL abort it with no gnt/rvalid issued afterward; operation resumes on first edge after release.

Verification
REQ-028 Single write: c0 we=1, addr=0x00010, wdata=0xDEADBEEF, be=0xF -> next cycle WR, WE_N=0, dq_oe=1, c0_gnt=1; busy 1 cycle.
REQ-029 Read back: c0 read 0x00010, SRAM model returns 0xDEADBEEF -> c0_rvalid with rdata=0xDEADBEEF exactly 3 cycles after c0_gnt.
REQ-030 Tie after reset: c0 and c1 both request same cycle -> c0 granted first, c1 second, then alternation on continuous ties.
REQ-031 Byte write: c1 be=0x5 -> SRAM_BE_N=0xA during WR.
REQ-032 Reset asserted during RD_WAIT -> outputs at reset values that cycle, no rvalid, next request served normally.
REQ-033 Read immediately followed by write from other core -> dq_oe never 1 while OE_N=0; one IDLE cycle separates them.
